// File: rtl/mux_sel_sequencer.sv
// Select-side driver for the 2-bit 4:1 board mux: switch sync/debounce, manual or
// round-robin select, and a 4-slot snapshot of the returned mux result.
module mux_sel_sequencer #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned DWELL        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw_sel,
    input  logic       sw_auto,
    input  logic [1:0] mux_f,
    output logic [1:0] sel,
    output logic [7:0] capture,
    output logic       cap_valid,
    output logic       frame_done
);

    localparam int unsigned CntW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0]   CntLast   = CntW'(DEBOUNCE_CYC - 1);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);

    typedef enum logic {StManual, StAuto} state_e;

    // Switch vector layout: bit 2 = auto mode, bits 1:0 = manual select.
    logic [2:0]        sync1_q, s_q, p_q, stable_q, stable_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0][1:0]   cap_q, cap_d;
    logic              cap_valid_q, cap_valid_d;
    logic              frame_done_q, frame_done_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (s_q == p_q && s_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        dwell_d      = dwell_q;
        cap_d        = cap_q;
        cap_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            StManual: begin
                if (stable_q[2]) begin
                    state_d = StAuto;
                    sel_d   = 2'd0;
                    dwell_d = '0;
                end else begin
                    sel_d        = stable_q[1:0];
                    cap_d[sel_q] = mux_f;
                end
            end
            StAuto: begin
                // Mode exit wins over a coincident dwell terminal: no capture, no pulse.
                if (!stable_q[2]) begin
                    state_d = StManual;
                    sel_d   = stable_q[1:0];
                    dwell_d = '0;
                end else if (dwell_q == DwellLast) begin
                    cap_d[sel_q] = mux_f;
                    sel_d        = sel_q + 2'd1;
                    dwell_d      = '0;
                    cap_valid_d  = 1'b1;
                    frame_done_d = (sel_q == 2'd3);
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = StManual;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            s_q          <= '0;
            p_q          <= '0;
            stable_q     <= '0;
            cnt_q        <= '0;
            dwell_q      <= '0;
            state_q      <= StManual;
            sel_q        <= '0;
            cap_q        <= '0;
            cap_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sync1_q      <= {sw_auto, sw_sel};
            s_q          <= sync1_q;
            p_q          <= s_q;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            state_q      <= state_d;
            sel_q        <= sel_d;
            cap_q        <= cap_d;
            cap_valid_q  <= cap_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign capture    = cap_q;
    assign cap_valid  = cap_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: directed stimulus, capture pulses checked by a
// scoreboard monitor against hand-computed snapshots and edge numbers.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw_sel;
    logic       sw_auto;
    logic [1:0] mux_f;
    logic [1:0] sel;
    logic [7:0] capture;
    logic       cap_valid;
    logic       frame_done;

    logic [1:0] x [4];
    assign mux_f = x[sel];

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  cap;
        logic        fd;
    } exp_t;
    exp_t sb[$];

    mux_sel_sequencer #(
        .DEBOUNCE_CYC(4),
        .DWELL(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_sel    (sw_sel),
        .sw_auto   (sw_auto),
        .mux_f     (mux_f),
        .sel       (sel),
        .capture   (capture),
        .cap_valid (cap_valid),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_edge(input int unsigned n);
        while (cyc < n) tick();
    endtask

    task automatic push(input int unsigned c, input logic [7:0] cap, input logic fd);
        exp_t e;
        e.cyc = c;
        e.cap = cap;
        e.fd  = fd;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (cap_valid || frame_done)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected cap_valid=%b frame_done=%b at cycle %0d, required none",
                         cap_valid, frame_done, cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || capture !== e.cap || frame_done !== e.fd || cap_valid !== 1'b1)
                begin
                    errors++;
                    $display("FAIL pulse: got cyc=%0d cap=%0h fd=%b cv=%b, required cyc=%0d cap=%0h fd=%b cv=1",
                             cyc, capture, frame_done, cap_valid, e.cyc, e.cap, e.fd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned t0, e0, t1, e2;
        logic [7:0]  cv;

        rst_n   = 1'b0;
        sw_sel  = 2'b00;
        sw_auto = 1'b0;
        x[0] = 2'd1; x[1] = 2'd2; x[2] = 2'd3; x[3] = 2'd0;

        #12;
        check("reset outputs", {sel, capture, cap_valid, frame_done}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("post-reset sel", sel, 2'd0);
        check("post-reset capture slot0", capture, 8'h01);

        // Manual select with debounce latency
        t0 = cyc;
        sw_sel = 2'b10;
        wait_edge(t0 + 7);
        check("manual sel before latency", sel, 2'd0);
        wait_edge(t0 + 8);
        check("manual sel at edge 8", sel, 2'd2);
        wait_edge(t0 + 9);
        check("manual capture at edge 9", capture, 8'h31);

        // 3-cycle select glitch is filtered
        tick();
        sw_sel = 2'b01;
        tick(); tick(); tick();
        sw_sel = 2'b10;
        repeat (12) tick();
        check("glitch sel unchanged", sel, 2'd2);
        check("glitch capture unchanged", capture, 8'h31);

        // Auto scan: frames, glitch on sw_auto, exit on a terminal edge
        x[0] = 2'd0; x[1] = 2'd1; x[2] = 2'd2; x[3] = 2'd3;
        tick();
        t0 = cyc;
        e0 = t0 + 8;
        for (int k = 1; k <= 14; k++) begin
            cv = (k == 1) ? 8'h20 : (k <= 3) ? 8'h24 : 8'hE4;
            push(e0 + 8 * k, cv, (k % 4) == 0);
        end
        sw_auto = 1'b1;
        wait_edge(e0 - 1);
        check("auto entry pending", sel, 2'd2);
        wait_edge(e0);
        check("auto entry sel", sel, 2'd0);
        for (int k = 1; k <= 14; k++) begin
            wait_edge(e0 + 8 * k - 1);
            check("auto sel hold", sel, (k - 1) % 4);
            wait_edge(e0 + 8 * k);
            check("auto sel step", sel, k % 4);
            if (k == 9) begin
                sw_auto = 1'b0;
                tick(); tick();
                sw_auto = 1'b1;
            end
        end
        sw_sel  = 2'b01;
        sw_auto = 1'b0;
        x[2]    = 2'd0;
        wait_edge(e0 + 119);
        check("exit pending sel", sel, 2'd2);
        wait_edge(e0 + 120);
        check("exit sel from switches", sel, 2'd1);
        check("exit no cap_valid", cap_valid, 1'b0);
        check("exit slot2 kept", capture[5:4], 2'd2);
        wait_edge(e0 + 122);
        check("manual after exit capture", capture, 8'hE4);

        // Reset asserted mid-scan
        tick();
        t1 = cyc;
        e2 = t1 + 8;
        push(e2 + 8, 8'hE4, 1'b0);
        push(e2 + 16, 8'hE4, 1'b0);
        sw_auto = 1'b1;
        wait_edge(e2 + 16);
        check("rescan sel", sel, 2'd2);
        @(negedge clk);
        #2;
        check("cap_valid before reset", cap_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset sel", sel, 2'd0);
        check("async reset capture", capture, 8'h00);
        check("async reset pulses", {cap_valid, frame_done}, 2'b00);
        sw_auto = 1'b0;
        sw_sel  = 2'b00;
        #8 rst_n = 1'b1;
        repeat (20) tick();
        check("after reset sel", sel, 2'd0);
        check("after reset capture", capture, 8'h00);
        check("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Select-side driver and result capture for the 2-bit 4-to-1 board mux. Synchronises and debounces the raw board switches, drives the mux select either manually from switches or by automatic round-robin scan, and registers the returned 2-bit mux output into a 4-slot snapshot for LED display. Sits directly upstream of the mux select input and directly downstream of its result output.

## Interface

- `DEBOUNCE_CYC`, default 4: consecutive stable synchronised cycles required to accept a switch change; must be ≥1.
- `DWELL`, default 8: cycles each select value is held in auto mode; must be ≥1.
- Counter widths are `$clog2` of the parameter, minimum 1 bit.

Ports (reset is asynchronous, active-low):

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `sw_sel` in 2: raw manual-select switches, asynchronous.
- `sw_auto` in 1: raw mode switch, asynchronous; 1 = auto scan.
- `mux_f` in 2: combinational result from the mux, a function of `sel` in the same cycle.
- `sel` out 2: registered select to the mux.
- `capture` out 8: slot i at bits [2i+1:2i].
- `cap_valid` out 1: one-cycle pulse after each auto-mode capture.
- `frame_done` out 1: one-cycle pulse after slot 3 is captured in auto mode.

## Operation

- **Sync:** the 3-bit vector {sw_auto, sw_sel} passes through two flops to give `s`. Register `p` holds `s` delayed by one cycle.
- **Debounce:** operates on the whole 3-bit vector, with counter `cnt` and accepted value `stable`.
  - If s≠p: cnt←0.
  - Else if s≠stable: when cnt==DEBOUNCE_CYC-1, stable←s and cnt←0; otherwise cnt++.
  - Else: cnt←0.
  - A glitch shorter than DEBOUNCE_CYC+1 cycles never reaches `stable`.
- **State machine:** two states, MANUAL (reset) and AUTO.
  - MANUAL→AUTO when stable.auto==1: sel←0, dwell←0.
  - AUTO→MANUAL when stable.auto==0: sel←stable.sel, dwell←0.
  - Transition edges perform no capture and generate no pulses.
- **MANUAL:**
  - sel←stable.sel every cycle.
  - capture[slot sel]←mux_f every cycle.
  - cap_valid=0 and frame_done=0.
- **AUTO:** dwell counts 0..DWELL-1. On the terminal cycle (dwell==DWELL-1):
  - capture[slot sel]←mux_f;
  - sel←sel+1, wrapping 3→0;
  - dwell←0;
  - cap_valid←1, and frame_done←1 if sel was 3.
  - On all other AUTO cycles, dwell++ and both pulses are 0.
- **Simultaneous events:** a mode exit on an edge that is also a dwell terminal takes priority. No capture occurs and no pulse is generated. A frame aborted mid-scan leaves the already-captured slots intact.
- Slots that are not currently selected keep their values.

## Timing

- **Reset values:** sel=0, capture=0x00, cap_valid=0, frame_done=0, state=MANUAL. All sync, p, stable, cnt and dwell registers are 0.
- **Reset mid-scan:** reset asserted during a scan returns everything to the reset values immediately (asynchronously). There is no partial frame_done.
- **Switch latency:** a raw change that is set up before edge 1 and held steady reaches `stable` at edge 3+DEBOUNCE_CYC. For the default of 4, that is edge 7.
- **Select and mode latency:** `sel` (in MANUAL) and the state change follow `stable` one edge later. For the default, that is edge 8.
- **Capture latency in MANUAL:** `capture` reflects the mux result for a new sel one edge after sel updates.
- **AUTO cadence:** with AUTO entered at edge E:
  - captures occur at edges E+DWELL·k;
  - sel steps to k mod 4 at those same edges;
  - the first frame completes at edge E+4·DWELL, with frame_done high for the following cycle;
  - with DWELL=1, cap_valid is high continuously and sel changes every cycle.

## Test plan

1. **Reset:** assert rst_n=0 mid-AUTO, between clock edges → all outputs are 0 immediately. Release reset → state is MANUAL and sel=0.
2. **Manual debounce:** set sw_sel=2'b10 steady before edge 1, with defaults → sel=2 at edge 8, and capture[5:4] equals the mux X2 value at edge 9. A 3-cycle sw_sel pulse leaves sel unchanged.
3. **Auto frame:** X0..X3=0,1,2,3; sw_auto=1; DWELL=8 →
   - sel sequence 0,1,2,3,0 on steps 8 edges apart;
   - cap_valid pulses 4 times;
   - frame_done pulses once, after the 4th capture;
   - capture=8'b11_10_01_00.
4. **Wrap / continuous scan:** keep AUTO on for 3 frames → frame_done pulses 3 times, spaced exactly 32 cycles apart, and sel wraps 3→0 each time.
5. **Exit on terminal cycle:** time sw_auto=0 so the exit edge coincides with the dwell==7 edge while sel=2 → slot 2 is unchanged, no cap_valid pulse, and sel=stable.sel on that edge.
6. **Glitch during AUTO:** a 2-cycle sw_auto=0 glitch → stays in AUTO and the scan cadence is undisturbed.
